fwb_slave_monitor: RTL and testbench
====================================

// Module: fwb_slave_monitor
// PURPOSE
//  Wishbone B4 pipelined-bus protocol monitor, seen from the slave side.
//  - Bound beside any WB slave; it only observes the bus and drives no bus signal.
//  - Counts accepted requests and returned acks, and exports the counters.
//  - Flags master-side (stimulus) and slave-side (DUT) rule violations.
//  - Reused by formal harnesses and simulation benches of every WB peripheral.
// PARAMETERS
//  AW                   30  address width (word address)
//  DW                   32  data width; sel width = DW/8
//  F_LGDEPTH            4   width of request/ack/outstanding counters
//  F_MAX_STALL          0   max consecutive stalled stb cycles; 0 = unchecked
//  F_MAX_ACK_DELAY      0   max cycles with outstanding>0 and no ack/err; 0 = unchecked
//  F_MAX_REQUESTS       0   max requests per cyc; 0 = limit is 2^F_LGDEPTH-2
//  F_OPT_RMW_BUS_OPTION 1   1: cyc may stay high with nothing outstanding
//  F_OPT_DISCONTINUOUS  1   1: stb may drop and re-rise within one cyc
//  F_OPT_MINCLOCK_DELAY 1   1: ack/err never in same cycle as its request
// PORTS
//  Interface: one clock; reset is synchronous and active-high.
//  i_clk          in   1          bus clock, all logic on rising edge
//  i_reset        in   1          synchronous active-high reset
//  i_wb_cyc       in   1          master cycle
//  i_wb_stb       in   1          master strobe
//  i_wb_we        in   1          write enable
//  i_wb_addr      in   AW         address
//  i_wb_data      in   DW         write data
//  i_wb_sel       in   DW/8       byte selects
//  i_wb_ack       in   1          slave ack
//  i_wb_stall     in   1          slave stall
//  i_wb_idata     in   DW         slave read data (observed, not checked)
//  i_wb_err       in   1          slave error
//  f_nreqs        out  F_LGDEPTH  requests accepted this cyc
//  f_nacks        out  F_LGDEPTH  acks+errs returned this cyc
//  f_outstanding  out  F_LGDEPTH  f_nreqs - f_nacks, combinational
//  f_master_err   out  1          sticky master-rule violation
//  f_slave_err    out  1          sticky slave-rule violation
// BEHAVIOUR
//  Reset values: f_nreqs, f_nacks, f_master_err and f_slave_err are 0.
//  Event definitions:
//  - Accept: cyc && stb && !stall.
//  - Response: ack || err.
//  Counters:
//  - Reset, !cyc, or err forces f_nreqs and f_nacks to 0 next cycle.
//  - Otherwise f_nreqs += accept and f_nacks += response.
//  Error flags:
//  - Each check is sampled at the clock edge.
//  - A violating flag rises on the following cycle and holds until reset.
//  Master rules (any failure -> f_master_err):
//  - stb with cyc low.
//  - cyc or stb high in the cycle after reset.
//  - stb && stall last cycle and stb now, but we/addr/sel changed; data changed on a write.
//  - we changed while outstanding>0.
//  - cyc still high the cycle after an err.
//  - Accept while f_nreqs is at the limit.
//  - F_OPT_DISCONTINUOUS=0 only: stb rises again after falling inside one cyc.
//  - F_OPT_RMW_BUS_OPTION=0 only: cyc high, stb low and outstanding==0 for a 2nd consecutive cycle.
//  Slave rules (any failure -> f_slave_err):
//  - ack and err high together.
//  - ack or err in the cycle after reset.
//  - ack or err while cyc is low.
//  - Response when no request is pending.
//    - F_OPT_MINCLOCK_DELAY=1: pending means outstanding>0.
//    - F_OPT_MINCLOCK_DELAY=0: pending means outstanding>0 or accept in the same cycle.
//  - F_MAX_STALL>0: stall held with stb high for more than F_MAX_STALL consecutive cycles.
//  - F_MAX_ACK_DELAY>0: outstanding>0 with no response for more than F_MAX_ACK_DELAY consecutive cycles.
//  Stall and delay counters clear on reset, !cyc, or on progress (accept / response).
// TESTING
//  1 Idle cyc=0 after reset -> counters 0, both err flags 0.
//  2 Pipelined writes to addrs 1,2,3 with stall=0, acks 1 cycle later:
//    f_nreqs 1,2,3; f_outstanding peaks at 1; no errors; drop cyc -> counters 0.
//  3 ack=1 with outstanding=0 -> f_slave_err=1 next cycle; stays set until i_reset.
//  4 stb=1 with stall=1, addr changes 5->6 next cycle -> f_master_err=1.
//  5 ack and err asserted together after a read -> f_slave_err=1.
//  6 MINCLOCK_DELAY=1, ack in the accept cycle -> f_slave_err=1.
//    MINCLOCK_DELAY=0, same stimulus -> no error.

Source files
------------

// File: rtl/fwb_slave_monitor.sv
// Passive Wishbone B4 pipelined-bus monitor seen from the slave side.
// Counts requests and acks in the current cycle and raises sticky flags for master or slave rule violations.
module fwb_slave_monitor #(
  parameter int AW                   = 30,
  parameter int DW                   = 32,
  parameter int F_LGDEPTH            = 4,
  parameter int F_MAX_STALL          = 0,
  parameter int F_MAX_ACK_DELAY      = 0,
  parameter int F_MAX_REQUESTS       = 0,
  parameter int F_OPT_RMW_BUS_OPTION = 1,
  parameter int F_OPT_DISCONTINUOUS  = 1,
  parameter int F_OPT_MINCLOCK_DELAY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [AW-1:0]        i_wb_addr,
  input  logic [DW-1:0]        i_wb_data,
  input  logic [DW/8-1:0]      i_wb_sel,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_stall,
  input  logic [DW-1:0]        i_wb_idata,
  input  logic                 i_wb_err,
  output logic [F_LGDEPTH-1:0] f_nreqs,
  output logic [F_LGDEPTH-1:0] f_nacks,
  output logic [F_LGDEPTH-1:0] f_outstanding,
  output logic                 f_master_err,
  output logic                 f_slave_err
);

  localparam int SW = DW / 8;
  localparam int CW = 16;
  localparam logic [F_LGDEPTH-1:0] REQ_LIMIT = (F_MAX_REQUESTS == 0) ?
      F_LGDEPTH'((1 << F_LGDEPTH) - 2) : F_LGDEPTH'(F_MAX_REQUESTS);
  localparam logic [CW-1:0] STALL_LIM = CW'(F_MAX_STALL);
  localparam logic [CW-1:0] ACK_LIM   = CW'(F_MAX_ACK_DELAY);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic                 accept, response, pending;
  logic                 master_viol, slave_viol;
  logic [F_LGDEPTH-1:0] outstanding;
  logic                 unused_idata;

  logic [F_LGDEPTH-1:0] nreqs_q, nreqs_d, nacks_q, nacks_d;
  logic                 master_err_q, master_err_d, slave_err_q, slave_err_d;
  logic                 past_reset_q, past_reset_d, past_err_q, past_err_d;
  logic                 hold_q, hold_d, stb_q, stb_d;
  logic                 stb_dropped_q, stb_dropped_d, idle_q, idle_d;
  logic [CW-1:0]        stall_cnt_q, stall_cnt_d, delay_cnt_q, delay_cnt_d;

  logic                 we_q, we_d, last_we_q, last_we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        data_q, data_d;
  logic [SW-1:0]        sel_q, sel_d;

  assign accept        = i_wb_cyc & i_wb_stb & ~i_wb_stall;
  assign response      = i_wb_ack | i_wb_err;
  assign outstanding   = nreqs_q - nacks_q;
  assign pending       = (outstanding != '0) || ((F_OPT_MINCLOCK_DELAY == 0) && accept);
  assign unused_idata  = ^i_wb_idata;

  assign f_nreqs       = nreqs_q;
  assign f_nacks       = nacks_q;
  assign f_outstanding = outstanding;
  assign f_master_err  = master_err_q;
  assign f_slave_err   = slave_err_q;

  always_comb begin
    nreqs_d       = nreqs_q + {{(F_LGDEPTH-1){1'b0}}, accept};
    nacks_d       = nacks_q + {{(F_LGDEPTH-1){1'b0}}, response};
    if (!i_wb_cyc || i_wb_err) begin
      nreqs_d = '0;
      nacks_d = '0;
    end
    past_reset_d  = 1'b0;
    past_err_d    = i_wb_err;
    hold_d        = i_wb_cyc & i_wb_stb & i_wb_stall;
    stb_d         = i_wb_cyc & i_wb_stb;
    stb_dropped_d = i_wb_cyc & (stb_dropped_q | (stb_q & ~i_wb_stb));
    idle_d        = i_wb_cyc & ~i_wb_stb & (outstanding == '0);
    // Stall and ack-delay run lengths restart whenever the bus makes progress
    stall_cnt_d   = '0;
    delay_cnt_d   = '0;
    if (i_wb_cyc && !accept && !response) begin
      if (i_wb_stb && i_wb_stall) stall_cnt_d = sat_inc(stall_cnt_q);
      if (outstanding != '0)      delay_cnt_d = sat_inc(delay_cnt_q);
    end
    we_d      = i_wb_we;
    addr_d    = i_wb_addr;
    data_d    = i_wb_data;
    sel_d     = i_wb_sel;
    last_we_d = accept ? i_wb_we : last_we_q;
  end

  always_comb begin
    master_viol = 1'b0;
    if (i_wb_stb && !i_wb_cyc) master_viol = 1'b1;
    if (past_reset_q && (i_wb_cyc || i_wb_stb)) master_viol = 1'b1;
    if (hold_q && i_wb_stb && ((i_wb_we != we_q) || (i_wb_addr != addr_q) ||
        (i_wb_sel != sel_q) || (i_wb_we && (i_wb_data != data_q))))
      master_viol = 1'b1;
    if (i_wb_cyc && i_wb_stb && (outstanding != '0) && (i_wb_we != last_we_q))
      master_viol = 1'b1;
    if (past_err_q && i_wb_cyc) master_viol = 1'b1;
    if (accept && (nreqs_q >= REQ_LIMIT)) master_viol = 1'b1;
    if ((F_OPT_DISCONTINUOUS == 0) && i_wb_cyc && i_wb_stb && stb_dropped_q)
      master_viol = 1'b1;
    if ((F_OPT_RMW_BUS_OPTION == 0) && idle_q && i_wb_cyc && !i_wb_stb && (outstanding == '0))
      master_viol = 1'b1;

    slave_viol = 1'b0;
    if (i_wb_ack && i_wb_err) slave_viol = 1'b1;
    if (past_reset_q && response) slave_viol = 1'b1;
    if (response && !i_wb_cyc) slave_viol = 1'b1;
    if (response && !pending) slave_viol = 1'b1;
    if ((F_MAX_STALL > 0) && i_wb_cyc && i_wb_stb && i_wb_stall && !response &&
        (stall_cnt_q >= STALL_LIM))
      slave_viol = 1'b1;
    if ((F_MAX_ACK_DELAY > 0) && i_wb_cyc && (outstanding != '0) && !response && !accept &&
        (delay_cnt_q >= ACK_LIM))
      slave_viol = 1'b1;

    master_err_d = master_err_q | master_viol;
    slave_err_d  = slave_err_q | slave_viol;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      nreqs_q       <= '0;
      nacks_q       <= '0;
      master_err_q  <= 1'b0;
      slave_err_q   <= 1'b0;
      past_reset_q  <= 1'b1;
      past_err_q    <= 1'b0;
      hold_q        <= 1'b0;
      stb_q         <= 1'b0;
      stb_dropped_q <= 1'b0;
      idle_q        <= 1'b0;
      stall_cnt_q   <= '0;
      delay_cnt_q   <= '0;
    end else begin
      nreqs_q       <= nreqs_d;
      nacks_q       <= nacks_d;
      master_err_q  <= master_err_d;
      slave_err_q   <= slave_err_d;
      past_reset_q  <= past_reset_d;
      past_err_q    <= past_err_d;
      hold_q        <= hold_d;
      stb_q         <= stb_d;
      stb_dropped_q <= stb_dropped_d;
      idle_q        <= idle_d;
      stall_cnt_q   <= stall_cnt_d;
      delay_cnt_q   <= delay_cnt_d;
    end
  end

  // Bus snapshot; only read while a reset-cleared qualifier is set
  always_ff @(posedge i_clk) begin
    we_q      <= we_d;
    addr_q    <= addr_d;
    data_q    <= data_d;
    sel_q     <= sel_d;
    last_we_q <= last_we_d;
  end

endmodule

// File: tb/tb_fwb_slave_monitor.sv
// Bench for fwb_slave_monitor: directed rule checks plus randomized legal bursts scored against a queue model.
module tb_fwb_slave_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, ack, stall, err;
  logic [29:0] addr;
  logic [31:0] data, idata;
  logic [3:0]  sel;

  logic [3:0] nreqs, nacks, outst, nreqs_b, nacks_b, outst_b;
  logic       merr, serr, merr_b, serr_b;

  int n_checks = 0;
  int n_fail   = 0;

  int reqs[$];
  int acked;

  always #5 clk = ~clk;

  fwb_slave_monitor #(.F_MAX_STALL(4), .F_MAX_ACK_DELAY(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(data), .i_wb_sel(sel), .i_wb_ack(ack),
    .i_wb_stall(stall), .i_wb_idata(idata), .i_wb_err(err),
    .f_nreqs(nreqs), .f_nacks(nacks), .f_outstanding(outst),
    .f_master_err(merr), .f_slave_err(serr));

  fwb_slave_monitor #(.F_OPT_MINCLOCK_DELAY(0), .F_OPT_DISCONTINUOUS(0),
                      .F_OPT_RMW_BUS_OPTION(0)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(data), .i_wb_sel(sel), .i_wb_ack(ack),
    .i_wb_stall(stall), .i_wb_idata(idata), .i_wb_err(err),
    .f_nreqs(nreqs_b), .f_nacks(nacks_b), .f_outstanding(outst_b),
    .f_master_err(merr_b), .f_slave_err(serr_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc = 0; stb = 0; we = 0; ack = 0; stall = 0; err = 0;
    addr = '0; data = '0; sel = 4'hf;
  endtask

  task automatic do_reset();
    idle_bus();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idata = '0;
    do_reset();

    // 1: idle after reset
    chk("reset_nreqs", nreqs, 0);
    chk("reset_nacks", nacks, 0);
    chk("reset_outst", outst, 0);
    chk("reset_merr", merr, 0);
    chk("reset_serr", serr, 0);
    tick(); tick();
    chk("idle_merr", merr, 0);
    chk("idle_serr", serr, 0);

    // 2: pipelined writes, ack one cycle later
    cyc = 1; stb = 1; we = 1; addr = 1; data = 32'h11;
    tick();
    chk("pw_nreqs1", nreqs, 1);
    chk("pw_outst1", outst, 1);
    addr = 2; data = 32'h22; ack = 1;
    tick();
    chk("pw_nreqs2", nreqs, 2);
    chk("pw_outst2", outst, 1);
    addr = 3; data = 32'h33;
    tick();
    chk("pw_nreqs3", nreqs, 3);
    chk("pw_outst3", outst, 1);
    stb = 0;
    tick();
    chk("pw_nacks3", nacks, 3);
    chk("pw_outst_end", outst, 0);
    cyc = 0; ack = 0;
    tick();
    chk("pw_drop_nreqs", nreqs, 0);
    chk("pw_drop_nacks", nacks, 0);
    chk("pw_merr", merr, 0);
    chk("pw_serr", serr, 0);

    // 3: ack with nothing outstanding, sticky until reset
    do_reset();
    cyc = 1; ack = 1;
    tick();
    ack = 0;
    chk("spur_ack_serr", serr, 1);
    chk("spur_ack_merr", merr, 0);
    cyc = 0;
    tick(); tick(); tick();
    chk("spur_ack_sticky", serr, 1);
    do_reset();
    chk("spur_ack_cleared", serr, 0);

    // 4: address changes while stalled
    cyc = 1; stb = 1; stall = 1; we = 0; addr = 5;
    tick();
    chk("stall_hold_ok", merr, 0);
    addr = 6;
    tick();
    chk("stall_addr_change", merr, 1);

    // 5: ack and err together after a read
    do_reset();
    cyc = 1; stb = 1; we = 0; addr = 9;
    tick();
    stb = 0; ack = 1; err = 1;
    tick();
    chk("ackerr_serr", serr, 1);
    chk("ackerr_nreqs", nreqs, 0);
    chk("ackerr_nacks", nacks, 0);
    idle_bus();
    tick();
    chk("ackerr_merr", merr, 0);

    // 6: ack in the accept cycle
    do_reset();
    cyc = 1; stb = 1; ack = 1; addr = 4;
    tick();
    chk("minclk1_serr", serr, 1);
    chk("minclk0_serr", serr_b, 0);
    chk("minclk0_nreqs", nreqs_b, 1);
    chk("minclk0_nacks", nacks_b, 1);
    idle_bus();
    tick();
    chk("minclk0_merr", merr_b, 0);

    // stall run-length boundary (limit 4)
    do_reset();
    cyc = 1; stb = 1; stall = 1; addr = 7;
    repeat (4) tick();
    chk("stall4_serr", serr, 0);
    tick();
    chk("stall5_serr", serr, 1);
    chk("stall5_merr", merr, 0);

    // ack-delay boundary (limit 4)
    do_reset();
    cyc = 1; stb = 1; addr = 8;
    tick();
    stb = 0;
    repeat (4) tick();
    chk("delay4_serr", serr, 0);
    chk("delay4_outst", outst, 1);
    tick();
    chk("delay5_serr", serr, 1);

    // request limit 2^4-2 = 14
    do_reset();
    cyc = 1; stb = 1;
    for (int i = 0; i < 14; i++) begin
      addr = 30'(i);
      tick();
    end
    chk("limit14_nreqs", nreqs, 14);
    chk("limit14_merr", merr, 0);
    addr = 30'd14;
    tick();
    chk("limit15_merr", merr, 1);
    chk("limit15_serr", serr, 0);

    // idle cyc with nothing outstanding, non-RMW instance
    do_reset();
    cyc = 1;
    tick();
    chk("rmw_first_b", merr_b, 0);
    tick();
    chk("rmw_second_b", merr_b, 1);
    chk("rmw_second_a", merr, 0);

    // stb re-rises within a cyc, continuous-only instance
    do_reset();
    cyc = 1; stb = 1; addr = 1;
    tick();
    stb = 0; ack = 1;
    tick();
    stb = 1; ack = 0; addr = 2;
    tick();
    chk("disc_b", merr_b, 1);
    chk("disc_a", merr, 0);

    // randomized legal bursts against the queue model
    do_reset();
    for (int b = 0; b < 20; b++) begin
      int  nwant, issued, guard, stall_run, delay, out_before;
      bit  have_req, acc;
      nwant = $urandom_range(1, 10);
      issued = 0; guard = 0; stall_run = 0; delay = 0; have_req = 0;
      reqs.delete(); acked = 0;
      cyc = 1; we = 1'($urandom);
      while ((issued < nwant || have_req || (reqs.size() - acked) > 0) && guard < 200) begin
        guard++;
        if (!have_req && issued < nwant && $urandom_range(0, 3) != 0) begin
          have_req = 1; issued++;
          addr = 30'($urandom); data = $urandom; sel = 4'($urandom);
        end
        out_before = reqs.size() - acked;
        stb   = have_req;
        stall = have_req && stall_run < 3 && ($urandom_range(0, 2) == 0);
        ack   = (out_before > 0) && (delay >= 3 || $urandom_range(0, 1) == 1);
        idata = $urandom;
        tick();
        acc = stb && !stall;
        if (acc) begin
          reqs.push_back(int'(addr));
          have_req = 0;
        end
        if (ack) acked++;
        stall_run = (stb && stall) ? stall_run + 1 : 0;
        delay = (out_before > 0 && !ack) ? delay + 1 : 0;
        chk("rnd_nreqs", nreqs, reqs.size());
        chk("rnd_nacks", nacks, acked);
        chk("rnd_outst", outst, reqs.size() - acked);
      end
      chk("rnd_no_timeout", (guard < 200), 1);
      idle_bus();
      tick();
      reqs.delete(); acked = 0;
      chk("rnd_end_nreqs", nreqs, reqs.size());
      chk("rnd_merr", merr, 0);
      chk("rnd_serr", serr, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
